// File: rtl/fixed_point_divider_pkg.sv
// Shared fixed-point definitions for the divider and multiplier datapath.
// Holds the default Q4.4 format, FSM state encoding and saturation value.
package fxp_pkg;

   localparam int FXP_WIDTH = 8;
   localparam int FXP_FRAC  = 4;

   localparam logic [FXP_WIDTH-1:0] FXP_SAT = {FXP_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } fxp_state_t;

endpackage

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the fixed-point divider.
// The master supplies operands and accepts results; the slave is the divider.
interface fixed_point_divider_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             overflow;
   logic             div_zero;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result, overflow, div_zero
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result, overflow, div_zero
   );
endinterface

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module fxp_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r_in,
   input  logic             n_bit,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   r_out,
   output logic             q_bit
);
   logic [WIDTH:0] trial;

   // r_in < d always holds, so its top bit is zero and can be dropped.
   assign trial = {r_in[WIDTH-1:0], n_bit};

   always_comb begin
      r_out = trial;
      q_bit = 1'b0;
      if (trial >= {1'b0, d}) begin
         r_out = trial - {1'b0, d};
         q_bit = 1'b1;
      end
   end
endmodule

// File: rtl/fixed_point_divider.sv
// Sequential unsigned Q-format divider, one restoring step per clock,
// with valid/ready handshakes and saturation on quotient overflow.
module fixed_point_divider
   import fxp_pkg::*;
#(
   parameter int WIDTH = FXP_WIDTH,
   parameter int FRAC  = FXP_FRAC
) (
   input logic                 clk,
   input logic                 rst_n,
   fixed_point_divider_if.slave bus
);
   localparam int NW    = WIDTH + FRAC;
   localparam int CNT_W = $clog2(NW + 1);

   fxp_state_t       state;
   logic [NW-1:0]    n_sh;
   logic [NW-1:0]    q_sh;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH:0]   rem;
   logic [CNT_W-1:0] cnt;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] result_r;
   logic             overflow_r;
   logic             div_zero_r;

   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [NW-1:0]    q_next;
   logic [WIDTH:0]   fmt;

   function automatic logic [WIDTH-1:0] saturate();
      return {WIDTH{1'b1}};
   endfunction

   // Returns {overflow, result}; any set bit above the Q format saturates.
   function automatic logic [WIDTH:0] format_quotient(input logic [NW-1:0] q);
      if (q[NW-1:WIDTH] != '0)
         return {1'b1, saturate()};
      return {1'b0, q[WIDTH-1:0]};
   endfunction

   fxp_div_step #(.WIDTH(WIDTH)) u_step (
      .r_in  (rem),
      .n_bit (n_sh[NW-1]),
      .d     (d_reg),
      .r_out (rem_next),
      .q_bit (q_bit)
   );

   assign q_next = {q_sh[NW-2:0], q_bit};
   assign fmt    = format_quotient(q_next);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         n_sh        <= '0;
         q_sh        <= '0;
         d_reg       <= '0;
         rem         <= '0;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         overflow_r  <= 1'b0;
         div_zero_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  n_sh       <= {bus.a, {FRAC{1'b0}}};
                  d_reg      <= bus.b;
                  rem        <= '0;
                  q_sh       <= '0;
                  cnt        <= CNT_W'(NW);
                  in_ready_r <= 1'b0;
                  overflow_r <= 1'b0;
                  if (bus.b == '0) begin
                     state       <= DONE;
                     out_valid_r <= 1'b1;
                     result_r    <= saturate();
                     div_zero_r  <= 1'b1;
                  end else begin
                     state      <= CALC;
                     div_zero_r <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem  <= rem_next;
               n_sh <= n_sh << 1;
               q_sh <= q_next;
               cnt  <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
                  overflow_r  <= fmt[WIDTH];
                  result_r    <= fmt[WIDTH-1:0];
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.overflow  = overflow_r;
   assign bus.div_zero  = div_zero_r;
endmodule
